operand_truncation: RTL and testbench
=====================================

Name: operand_truncation

Overview:
- Inverse of the operand zero-extension path: narrows 16-bit datapath words (accumulator/ALU results) back into 11-bit operand fields.
- Used when writing results into operand-sized storage, e.g. data-memory address fields and instruction operand patching.
- Flags values that do not fit in the operand width, with either wrap (truncate) or saturate policy.
- Registered valid/ready stage with a 2-entry skid buffer, so upstream ready is a flop.

Parameters:
- IN_LENGTH, 16, width of incoming datapath word.
- OPERAND_LENGTH, 11, width of produced operand; must be < IN_LENGTH.
- SATURATE, 0, 0 = keep low OPERAND_LENGTH bits on overflow; 1 = output all-ones (2^OPERAND_LENGTH-1) on overflow.
- COUNT_WIDTH, 8, width of overflow event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- inData  input  IN_LENGTH  word to narrow.
- inValid  input  1  inData valid.
- inReady  output  1  block can accept; registered.
- outOperand  output  OPERAND_LENGTH  narrowed operand.
- outOverflow  output  1  per-word flag: upper bits of this word were nonzero; qualified by outValid.
- outValid  output  1  outOperand valid.
- outReady  input  1  downstream accepts.
- clrOverflow  input  1  synchronous clear of stickyOverflow and overflowCount.
- stickyOverflow  output  1  set by any accepted overflowing word.
- overflowCount  output  COUNT_WIDTH  number of accepted overflowing words, saturating.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: inReady=1, outValid=0, outOperand=0, outOverflow=0, stickyOverflow=0, overflowCount=0, state=EMPTY.
- Accept: accept = inValid & inReady. Transfer out: xfer = outValid & outReady.
- Narrowing, computed combinationally on inData and registered at accept:
  - ovf = |inData[IN_LENGTH-1:OPERAND_LENGTH], unsigned interpretation matching zero-extension.
  - Result = inData[OPERAND_LENGTH-1:0], or all-ones if SATURATE=1 and ovf=1.
  - The per-word ovf flag is stored alongside the result.
- Latency: a word accepted at edge N is presented on outOperand/outValid after edge N (1 cycle) when the buffer was empty.
- Storage: main register (drives outputs) and skid register.
- States:
  - EMPTY: outValid=0. accept -> load main -> ONE.
  - ONE: outValid=1.
    - accept & xfer -> load main, stay ONE.
    - accept & !xfer -> load skid -> TWO.
    - !accept & xfer -> EMPTY.
    - else hold.
  - TWO: inReady=0, outValid=1.
    - xfer -> main<=skid -> ONE.
    - else hold.
- inReady is registered, and equals 0 exactly when next state is TWO.
- No data loss or duplication under any inValid/outReady pattern. Order is preserved.
- Outputs are stable while outValid=1 & outReady=0.
- Counter/sticky updates occur on accept (not on transfer):
  - accept & ovf -> stickyOverflow<=1 and overflowCount<=overflowCount+1, held at 2^COUNT_WIDTH-1 (no wrap).
  - clrOverflow has priority over a simultaneous accept & ovf: result is 0 / 0, and that event is dropped.
- Boundaries:
  - inData = 2^OPERAND_LENGTH-1 (0x07FF) is not an overflow.
  - 0x0800 is an overflow.
  - 0xFFFF is an overflow.
- Reset asserted mid-operation: all buffered words are discarded, outputs return to reset values immediately (asynchronously), and the block restarts in EMPTY on deassertion.
- When outValid=0, outOperand and outOverflow retain the last value. The bench must not check them in that case.

Test Plan:
- Reset, then single word 0x03A5 with outReady=1 -> next cycle outValid=1, outOperand=0x3A5, outOverflow=0, overflowCount=0.
- Boundary words 0x07FF, 0x0800, 0xFFFF with SATURATE=0 -> outputs 0x7FF/0, 0x000/1, 0x7FF/1. With SATURATE=1 -> 0x7FF/0, 0x7FF/1, 0x7FF/1. overflowCount=2, stickyOverflow=1.
- Backpressure: outReady=0, inValid=1 streaming 0x0001, 0x0002, 0x0003.
  - 0x0001 is accepted and presented.
  - 0x0002 is accepted into skid, and inReady=0 the following cycle.
  - 0x0003 is held upstream.
  - Release outReady -> sequence 0x001, 0x002, 0x003 in order, no gaps beyond one cycle, no duplicates.
- Random valid/ready: 1000 random words with random inValid/outReady -> scoreboard matches order and values. overflowCount equals the reference count of words with [15:11]!=0, capped at 255.
- Saturation and clear:
  - 300 overflowing words -> overflowCount=255.
  - clrOverflow together with an overflowing accept -> count=0, sticky=0 next cycle.
  - Next overflowing word -> count=1.
- Reset mid-operation: rst_n low while in TWO -> outValid=0, inReady=1, counters 0 immediately. After release, a new word 0x0123 comes out alone as 0x123.

Source files
------------

// File: rtl/operand_truncation_if.sv
// ============================================================================
// Module : operand_truncation_if
// Brief  : Input word stream and narrowed-operand stream for operand_truncation
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface operand_truncation_if #(
    parameter int IN_LENGTH      = 16,
    parameter int OPERAND_LENGTH = 11
) ();
    logic [IN_LENGTH-1:0]      inData;
    logic                      inValid;
    logic                      inReady;
    logic [OPERAND_LENGTH-1:0] outOperand;
    logic                      outOverflow;
    logic                      outValid;
    logic                      outReady;

    modport master (
        output inData,
        output inValid,
        input  inReady,
        input  outOperand,
        input  outOverflow,
        input  outValid,
        output outReady
    );

    modport slave (
        input  inData,
        input  inValid,
        output inReady,
        output outOperand,
        output outOverflow,
        output outValid,
        input  outReady
    );
endinterface

`default_nettype wire

// File: rtl/operand_truncation.sv
// ============================================================================
// Module : operand_truncation
// Brief  : Narrows datapath words to operand width, flags/counts overflow,
//          through a registered two-entry skid stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module operand_truncation #(
    parameter int IN_LENGTH      = 16,
    parameter int OPERAND_LENGTH = 11,
    parameter int SATURATE       = 0,
    parameter int COUNT_WIDTH    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    operand_truncation_if.slave    bus,
    input  logic                   clrOverflow,
    output logic                   stickyOverflow,
    output logic [COUNT_WIDTH-1:0] overflowCount
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [OPERAND_LENGTH-1:0] main_data_q, main_data_d;
    logic [OPERAND_LENGTH-1:0] skid_data_q, skid_data_d;
    logic                      main_ovf_q, main_ovf_d;
    logic                      skid_ovf_q, skid_ovf_d;
    logic                      in_ready_q;
    logic                      out_valid_q;
    logic                      sticky_q, sticky_d;
    logic [COUNT_WIDTH-1:0]    count_q, count_d;

    logic                      w_accept;
    logic                      w_xfer;
    logic                      w_ovf;
    logic [OPERAND_LENGTH-1:0] w_result;

    assign w_accept = bus.inValid & in_ready_q;
    assign w_xfer   = out_valid_q & bus.outReady;

    // Unsigned view: any set bit above the operand field means the value does not fit.
    assign w_ovf    = |bus.inData[IN_LENGTH-1:OPERAND_LENGTH];
    assign w_result = ((SATURATE != 0) && w_ovf) ? {OPERAND_LENGTH{1'b1}}
                                                 : bus.inData[OPERAND_LENGTH-1:0];

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ovf_d  = main_ovf_q;
        skid_data_d = skid_data_q;
        skid_ovf_d  = skid_ovf_q;
        case (state_q)
            EMPTY: begin
                if (w_accept) begin
                    main_data_d = w_result;
                    main_ovf_d  = w_ovf;
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (w_accept && w_xfer) begin
                    main_data_d = w_result;
                    main_ovf_d  = w_ovf;
                end else if (w_accept) begin
                    skid_data_d = w_result;
                    skid_ovf_d  = w_ovf;
                    state_d     = TWO;
                end else if (w_xfer) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (w_xfer) begin
                    main_data_d = skid_data_q;
                    main_ovf_d  = skid_ovf_q;
                    state_d     = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Clear wins over a coincident overflowing accept; that event is lost.
    always_comb begin
        sticky_d = sticky_q;
        count_d  = count_q;
        if (clrOverflow) begin
            sticky_d = 1'b0;
            count_d  = '0;
        end else if (w_accept && w_ovf) begin
            sticky_d = 1'b1;
            if (count_q != {COUNT_WIDTH{1'b1}}) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_data_q <= '0;
            main_ovf_q  <= 1'b0;
            skid_data_q <= '0;
            skid_ovf_q  <= 1'b0;
            sticky_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != TWO);
            out_valid_q <= (state_d != EMPTY);
            main_data_q <= main_data_d;
            main_ovf_q  <= main_ovf_d;
            skid_data_q <= skid_data_d;
            skid_ovf_q  <= skid_ovf_d;
            sticky_q    <= sticky_d;
            count_q     <= count_d;
        end
    end

    assign bus.inReady     = in_ready_q;
    assign bus.outValid    = out_valid_q;
    assign bus.outOperand  = main_data_q;
    assign bus.outOverflow = main_ovf_q;
    assign stickyOverflow  = sticky_q;
    assign overflowCount   = count_q;

endmodule

`default_nettype wire

// File: tb/tb_operand_truncation.sv
// ============================================================================
// Module : tb_operand_truncation
// Brief  : Scoreboard bench driving wrap and saturate instances in lockstep.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_operand_truncation;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_data   = '0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic        clr       = 1'b0;

    always #5 clk = ~clk;

    operand_truncation_if #(.IN_LENGTH(16), .OPERAND_LENGTH(11)) if0 ();
    operand_truncation_if #(.IN_LENGTH(16), .OPERAND_LENGTH(11)) if1 ();

    assign if0.inData   = in_data;
    assign if0.inValid  = in_valid;
    assign if0.outReady = out_ready;
    assign if1.inData   = in_data;
    assign if1.inValid  = in_valid;
    assign if1.outReady = out_ready;

    logic       sticky0, sticky1;
    logic [7:0] cnt0, cnt1;

    operand_truncation #(.IN_LENGTH(16), .OPERAND_LENGTH(11), .SATURATE(0), .COUNT_WIDTH(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave), .clrOverflow(clr),
        .stickyOverflow(sticky0), .overflowCount(cnt0)
    );

    operand_truncation #(.IN_LENGTH(16), .OPERAND_LENGTH(11), .SATURATE(1), .COUNT_WIDTH(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave), .clrOverflow(clr),
        .stickyOverflow(sticky1), .overflowCount(cnt1)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [11:0] q0[$];
    logic [11:0] q1[$];
    int          pops0 = 0;
    int          pops1 = 0;
    int          ref_cnt = 0;
    bit          ref_sticky = 1'b0;
    logic [11:0] e0, e1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: value fits iff below 2^11; otherwise wrap modulo 2^11 or clamp to 2047.
    function automatic logic [11:0] narrow(input logic [15:0] w, input bit sat);
        int unsigned v;
        logic [10:0] op;
        logic        ovf;
        v   = w;
        ovf = (v >= 2048);
        if (!ovf)     op = 11'(v);
        else if (sat) op = 11'(2047);
        else          op = 11'(v % 2048);
        return {ovf, op};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (if0.outValid && if0.outReady) begin
                if (q0.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL dut0_unexpected: got 0x%0h expected no output", if0.outOperand);
                end else begin
                    e0 = q0.pop_front();
                    chk("dut0_operand", 32'(if0.outOperand), 32'(e0[10:0]));
                    chk("dut0_ovf", 32'(if0.outOverflow), 32'(e0[11]));
                    pops0++;
                end
            end
            if (if1.outValid && if1.outReady) begin
                if (q1.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL dut1_unexpected: got 0x%0h expected no output", if1.outOperand);
                end else begin
                    e1 = q1.pop_front();
                    chk("dut1_operand", 32'(if1.outOperand), 32'(e1[10:0]));
                    chk("dut1_ovf", 32'(if1.outOverflow), 32'(e1[11]));
                    pops1++;
                end
            end
        end
    end

    // One clock of stimulus; inputs change just after the edge, acceptance is judged mid-cycle.
    task automatic cycle(input bit v, input logic [15:0] d, input bit ordy, input bit c, output bit acc);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        clr       = c;
        @(negedge clk);
        acc = v && (if0.inReady === 1'b1);
        if (c) begin
            ref_cnt    = 0;
            ref_sticky = 1'b0;
        end
        if (acc) begin
            q0.push_back(narrow(d, 1'b0));
            q1.push_back(narrow(d, 1'b1));
            if (!c && d > 16'd2047) begin
                ref_sticky = 1'b1;
                if (ref_cnt < 255) ref_cnt++;
            end
        end
    endtask

    // ordy_mode: 0/1 fixed outReady, 2 random.
    task automatic send(input logic [15:0] d, input int ordy_mode, input bit rnd_valid);
        bit acc;
        bit v;
        bit o;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 64) begin
            v = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            o = (ordy_mode == 2) ? 1'($urandom_range(0, 1)) : (ordy_mode == 1);
            cycle(v, d, o, 1'b0, acc);
            n++;
        end
        if (!acc) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: got no accept expected accept of 0x%0h", d);
        end
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
            cycle(1'b0, 16'h0, 1'b1, 1'b0, acc);
            n++;
        end
        chk("drain_empty", 32'(q0.size() + q1.size()), 32'd0);
    endtask

    task automatic check_counters(input string tag);
        bit acc;
        cycle(1'b0, 16'h0, 1'b1, 1'b0, acc);
        chk({tag, "_cnt0"}, 32'(cnt0), 32'(ref_cnt));
        chk({tag, "_cnt1"}, 32'(cnt1), 32'(ref_cnt));
        chk({tag, "_sticky0"}, 32'(sticky0), 32'(ref_sticky));
        chk({tag, "_sticky1"}, 32'(sticky1), 32'(ref_sticky));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          acc;
        int          p0, p1;
        logic [15:0] w;

        // Reset state
        #12;
        chk("rst_inReady0", 32'(if0.inReady), 32'd1);
        chk("rst_inReady1", 32'(if1.inReady), 32'd1);
        chk("rst_outValid0", 32'(if0.outValid), 32'd0);
        chk("rst_outValid1", 32'(if1.outValid), 32'd0);
        chk("rst_cnt", 32'(cnt0), 32'd0);
        chk("rst_sticky", 32'(sticky0), 32'd0);
        #10;
        rst_n = 1'b1;

        // Single word, one-cycle latency
        cycle(1'b1, 16'h03A5, 1'b1, 1'b0, acc);
        chk("single_acc", 32'(acc), 32'd1);
        cycle(1'b0, 16'h0, 1'b1, 1'b0, acc);
        chk("single_valid0", 32'(if0.outValid), 32'd1);
        chk("single_valid1", 32'(if1.outValid), 32'd1);
        chk("single_cnt", 32'(cnt0), 32'd0);
        drain();

        // Boundary words
        send(16'h07FF, 1, 1'b0);
        send(16'h0800, 1, 1'b0);
        send(16'hFFFF, 1, 1'b0);
        drain();
        check_counters("bnd");
        chk("bnd_count_const", 32'(cnt0), 32'd2);

        // Backpressure: fill main and skid, then hold the third word upstream
        cycle(1'b1, 16'h0001, 1'b0, 1'b0, acc);
        chk("bp_acc1", 32'(acc), 32'd1);
        cycle(1'b1, 16'h0002, 1'b0, 1'b0, acc);
        chk("bp_acc2", 32'(acc), 32'd1);
        chk("bp_present1", 32'(if0.outOperand), 32'h001);
        cycle(1'b1, 16'h0003, 1'b0, 1'b0, acc);
        chk("bp_hold3a", 32'(acc), 32'd0);
        chk("bp_inReady0", 32'(if0.inReady), 32'd0);
        chk("bp_inReady1", 32'(if1.inReady), 32'd0);
        cycle(1'b1, 16'h0003, 1'b0, 1'b0, acc);
        chk("bp_hold3b", 32'(acc), 32'd0);
        chk("bp_stable", 32'(if0.outOperand), 32'h001);
        p0 = pops0;
        send(16'h0003, 1, 1'b0);
        drain();
        chk("bp_count_out", 32'(pops0 - p0), 32'd3);

        // Random traffic
        for (int i = 0; i < 1000; i++) begin
            w = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 2047))
                                            : 16'($urandom_range(0, 65535));
            send(w, 2, 1'b1);
        end
        drain();
        check_counters("rnd");

        // Saturation of the counter, then clear racing an overflowing accept
        cycle(1'b0, 16'h0, 1'b1, 1'b1, acc);
        check_counters("clr1");
        for (int i = 0; i < 300; i++) begin
            send(16'(16'h0800 + $urandom_range(0, 16'hF7FF)), 1, 1'b0);
        end
        drain();
        check_counters("sat");
        chk("sat_const", 32'(cnt0), 32'd255);
        cycle(1'b1, 16'hFFFF, 1'b1, 1'b1, acc);
        chk("clr_acc", 32'(acc), 32'd1);
        check_counters("clr2");
        chk("clr2_const", 32'(cnt1), 32'd0);
        send(16'h1234, 1, 1'b0);
        check_counters("post_clr");
        chk("post_clr_const", 32'(cnt0), 32'd1);
        drain();

        // Reset while two words are buffered
        cycle(1'b1, 16'h8001, 1'b0, 1'b0, acc);
        cycle(1'b1, 16'h8002, 1'b0, 1'b0, acc);
        @(posedge clk);
        #1;
        chk("pre_rst_full", 32'(if0.inReady), 32'd0);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mid_rst_valid0", 32'(if0.outValid), 32'd0);
        chk("mid_rst_valid1", 32'(if1.outValid), 32'd0);
        chk("mid_rst_ready", 32'(if0.inReady), 32'd1);
        chk("mid_rst_cnt", 32'(cnt0), 32'd0);
        chk("mid_rst_sticky", 32'(sticky1), 32'd0);
        q0.delete();
        q1.delete();
        ref_cnt    = 0;
        ref_sticky = 1'b0;
        #12;
        rst_n = 1'b1;
        p0 = pops0;
        p1 = pops1;
        send(16'h0123, 1, 1'b0);
        drain();
        chk("post_rst_single0", 32'(pops0 - p0), 32'd1);
        chk("post_rst_single1", 32'(pops1 - p1), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
